uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
- UART receiver with a small receive FIFO.
- Consumes the serial RXD line entering the SOC and presents received bytes to the CPU memory-mapped IO decoder via a valid/read handshake.
- Format is 8N1: 1 start bit, 8 data bits LSB first, 1 stop bit.
- Bit timing comes from a fixed clocks-per-bit divider. Sticky error flags report framing errors and FIFO overruns.

Parameters:
- CLKS_PER_BIT, 104, CLK cycles per serial bit (12 MHz / 115200). Must be >= 4.
- FIFO_DEPTH, 4, number of byte entries. Must be a power of two, >= 2.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-high reset.
- RXD  input  1  raw serial input, idle high, asynchronous to CLK.
- rx_read  input  1  pop strobe from the IO decoder, one cycle per byte.
- clear_err  input  1  clears the sticky error flags.
- rx_data  output  8  byte at the FIFO head; 8'h00 when the FIFO is empty.
- rx_valid  output  1  FIFO not empty.
- rx_count  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (async, RESET=1):
  - State = IDLE; bit counter and clock counter = 0.
  - Synchroniser flops = 1; FIFO pointers and count = 0.
  - rx_valid=0, rx_data=8'h00, rx_count=0, frame_err=0, overrun=0.
  - A byte in progress when reset asserts is discarded.
- Synchroniser: RXD passes through 2 flops to give rx_s. All decisions use rx_s, which adds 2 cycles of latency.
- FSM:
  - IDLE: when rx_s==0, go to START with clk_cnt=0.
  - START: when clk_cnt == CLKS_PER_BIT/2-1, sample rx_s.
    - Sample 0: go to DATA, clk_cnt=0, bit_idx=0.
    - Sample 1: glitch; return to IDLE with no side effects.
  - DATA: when clk_cnt == CLKS_PER_BIT-1, sample rx_s into shift[bit_idx] (LSB first) and reset clk_cnt. After bit_idx 7, go to STOP.
  - STOP: when clk_cnt == CLKS_PER_BIT-1, sample rx_s.
    - Sample 1: push the byte (see FIFO rules); go to IDLE.
    - Sample 0: set frame_err, discard the byte, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then go to IDLE. This covers break conditions: a line held low produces exactly one frame_err and no bytes.
- Push latency: the byte is visible on rx_data and rx_valid rises in the cycle after the stop-bit sample edge.
- FIFO rules:
  - Pop occurs on rx_read && rx_valid. rx_read while empty is ignored: pointers unchanged, no error.
  - Push while full and no pop in the same cycle: byte dropped, overrun set, FIFO contents unchanged.
  - Push and pop in the same cycle while full: both succeed, count unchanged, no overrun.
  - Push and pop in the same cycle while not full and not empty: count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - rx_data is combinational from the head entry and updates the cycle after a pop.
- Error flags:
  - clear_err clears both flags on the next edge.
  - If clear_err coincides with a new error event, the error wins and the flag stays 1.
- No other output changes while a byte is being received.

Test Plan (bench uses CLKS_PER_BIT=16, FIFO_DEPTH=4):
- Single byte 0xA5, well-formed, stop=1 -> rx_valid rises 1 cycle after the stop sample; rx_data=0xA5, rx_count=1. Pulse rx_read -> rx_valid=0, rx_data=0x00.
- Back-to-back bytes 0x01, 0x80, 0xFF, 0x3C with no reads -> rx_count=4, overrun=0. Four reads return the bytes in order.
- Five bytes 0x11..0x15 with no reads -> rx_count=4, overrun=1; reads return 0x11..0x14. clear_err -> overrun=0.
- Glitch: RXD low for 4 cycles, then high -> FSM returns to IDLE; rx_valid=0, no error flags.
- Byte 0x55 with stop=0, RXD then held low for 100 cycles and released -> frame_err=1, rx_count=0. Next well-formed byte 0x7E is received correctly.
- FIFO full with rx_read asserted in the push cycle of a 5th byte 0x99 -> overrun=0, rx_count stays 4, and 0x99 is read last. Separately, RESET mid-byte -> all outputs return to their reset values and no partial byte appears.

Source files
------------

// File: rtl/uart_rx_fifo.sv
// UART receiver (8N1) with a small byte FIFO and sticky error flags.
//
// Ports:
//   CLK       - system clock
//   RESET     - asynchronous, active-high reset
//   RXD       - raw serial input, idle high, asynchronous to CLK
//   rx_read   - pop strobe, one cycle per byte
//   clear_err - clears frame_err and overrun on the next edge
//   rx_data   - byte at the FIFO head, 8'h00 when empty
//   rx_valid  - FIFO not empty
//   rx_count  - FIFO occupancy
//   frame_err - sticky: a stop bit was sampled low
//   overrun   - sticky: a byte was dropped because the FIFO was full
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          RXD,
  input  logic                          rx_read,
  input  logic                          clear_err,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   rx_count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);

  localparam logic [CntW-1:0] HalfLast  = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast   = CntW'(CLKS_PER_BIT - 1);
  localparam logic [AddrW:0]  CountFull = (AddrW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StWaitHigh} state_e;

  // Two-flop synchroniser, reset to the idle line level.
  logic rx_meta_q, rx_s_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RXD;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Receive FSM
  state_e          state_q;
  logic [CntW-1:0] clk_cnt_q;
  logic [2:0]      bit_idx_q;
  logic [7:0]      shift_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_q   <= StStart;
            clk_cnt_q <= '0;
          end
        end
        StStart: begin
          // Mid-start-bit check rejects glitches shorter than half a bit.
          if (clk_cnt_q == HalfLast) begin
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s_q ? StIdle : StData;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        StData: begin
          if (clk_cnt_q == BitLast) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rx_s_q;
            if (bit_idx_q == 3'd7) begin
              state_q <= StStop;
            end else begin
              bit_idx_q <= bit_idx_q + 1'b1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        StStop: begin
          if (clk_cnt_q == BitLast) begin
            clk_cnt_q <= '0;
            state_q   <= rx_s_q ? StIdle : StWaitHigh;
          end else begin
            clk_cnt_q <= clk_cnt_q + 1'b1;
          end
        end
        StWaitHigh: begin
          // A held-low line (break) yields a single frame error.
          if (rx_s_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  logic stop_tick, push_ev, ferr_ev;

  always_comb begin
    stop_tick = (state_q == StStop) && (clk_cnt_q == BitLast);
    push_ev   = stop_tick && rx_s_q;
    ferr_ev   = stop_tick && !rx_s_q;
  end

  // Receive FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q, count_d;
  logic             pop, full, do_push, ovr_ev;

  always_comb begin
    pop     = rx_read && (count_q != '0);
    full    = (count_q == CountFull);
    // A pop in the same cycle frees the slot the incoming byte needs.
    do_push = push_ev && (!full || pop);
    ovr_ev  = push_ev && full && !pop;
    count_d = count_q;
    case ({do_push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_ptr_q] <= shift_q;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Sticky flags: a new error event beats a simultaneous clear.
  logic frame_err_q, overrun_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (ferr_ev)        frame_err_q <= 1'b1;
      else if (clear_err) frame_err_q <= 1'b0;
      if (ovr_ev)         overrun_q   <= 1'b1;
      else if (clear_err) overrun_q   <= 1'b0;
    end
  end

  always_comb begin
    rx_valid  = (count_q != '0);
    rx_data   = rx_valid ? mem_q[rd_ptr_q] : 8'h00;
    rx_count  = count_q;
    frame_err = frame_err_q;
    overrun   = overrun_q;
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 4;
  // Edge (counted from the edge before the start bit is driven) at which the
  // stop bit is sampled: 2 sync flops + 1 idle detect, half bit, 9 full bits.
  localparam int unsigned StopEdge = 3 + CPB / 2 + 9 * CPB;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       RXD = 1'b1;
  logic       rx_read = 1'b0;
  logic       clear_err = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_count;
  logic       frame_err;
  logic       overrun;

  uart_rx_fifo #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .RXD       (RXD),
    .rx_read   (rx_read),
    .clear_err (clear_err),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_count  (rx_count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 CLK = ~CLK;

  // Reference model: byte queue plus sticky flags.
  logic [7:0] mq[$];
  bit         m_ferr;
  bit         m_ovr;
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [7:0] head;
    head = (mq.size() > 0) ? mq[0] : 8'h00;
    chk({tag, ".count"}, rx_count, mq.size());
    chk({tag, ".valid"}, rx_valid, (mq.size() > 0) ? 1 : 0);
    chk({tag, ".data"}, rx_data, head);
    chk({tag, ".ferr"}, frame_err, m_ferr);
    chk({tag, ".ovr"}, overrun, m_ovr);
  endtask

  task automatic model_push(input logic [7:0] b, input bit pop_same);
    if (pop_same && mq.size() > 0) begin
      void'(mq.pop_front());
      mq.push_back(b);
    end else if (mq.size() < DEPTH) begin
      mq.push_back(b);
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  // Drives start, 8 data bits (LSB first) and the stop bit; leaves RXD at stop.
  task automatic send_bits(input logic [7:0] b, input bit stop);
    RXD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      RXD = b[i];
      tick(CPB);
    end
    RXD = stop;
    tick(CPB);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop, input bit pop_same);
    send_bits(b, stop);
    RXD = 1'b1;
    tick(4);
    if (stop) model_push(b, pop_same);
    else m_ferr = 1'b1;
  endtask

  task automatic do_read();
    rx_read = 1'b1;
    tick(1);
    rx_read = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic do_clear();
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    bit         stop;

    tick(3);
    chk("async_reset.valid", rx_valid, 0);
    RESET = 1'b0;
    tick(2);
    check_model("reset");

    // Single byte with push-latency probe
    fork
      send_byte(8'hA5, 1'b1, 1'b0);
      begin
        tick(StopEdge - 1);
        chk("lat.before", rx_valid, 0);
        tick(1);
        chk("lat.valid", rx_valid, 1);
        chk("lat.data", rx_data, 8'hA5);
        chk("lat.count", rx_count, 1);
      end
    join
    check_model("single");
    do_read();
    check_model("single.read");

    // Four back-to-back bytes fill the FIFO
    send_byte(8'h01, 1'b1, 1'b0);
    send_byte(8'h80, 1'b1, 1'b0);
    send_byte(8'hFF, 1'b1, 1'b0);
    send_byte(8'h3C, 1'b1, 1'b0);
    check_model("fill4");
    for (int i = 0; i < 4; i++) begin
      check_model("fill4.rd");
      do_read();
    end
    check_model("fill4.empty");
    do_read();
    check_model("empty.read");

    // Five bytes: fifth overruns
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i), 1'b1, 1'b0);
    check_model("ovr");
    for (int i = 0; i < 4; i++) begin
      check_model("ovr.rd");
      do_read();
    end
    do_clear();
    check_model("ovr.clear");

    // Start-bit glitch
    RXD = 1'b0;
    tick(4);
    RXD = 1'b1;
    tick(3 * CPB);
    check_model("glitch");

    // Bad stop bit followed by a break, then a good byte
    send_bits(8'h55, 1'b0);
    tick(100);
    chk("break.ferr", frame_err, 1);
    chk("break.count", rx_count, 0);
    m_ferr = 1'b1;
    RXD = 1'b1;
    tick(4);
    check_model("break");
    send_byte(8'h7E, 1'b1, 1'b0);
    check_model("after_break");
    do_read();
    do_clear();
    check_model("after_break.clear");

    // Full FIFO with a pop in the push cycle
    for (int i = 0; i < 4; i++) send_byte(8'(8'h21 + i), 1'b1, 1'b0);
    fork
      send_byte(8'h99, 1'b1, 1'b1);
      begin
        tick(StopEdge - 1);
        rx_read = 1'b1;
        tick(1);
        rx_read = 1'b0;
      end
    join
    check_model("pushpop");
    for (int i = 0; i < 4; i++) begin
      check_model("pushpop.rd");
      do_read();
    end
    check_model("pushpop.empty");

    // Randomized frames, reads and clears
    for (int n = 0; n < 14; n++) begin
      b    = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      send_byte(b, stop, 1'b0);
      check_model("rnd.frame");
      for (int r = 0; r < int'($urandom_range(0, 2)); r++) begin
        do_read();
        check_model("rnd.read");
      end
      if ($urandom_range(0, 3) == 0) begin
        do_clear();
        check_model("rnd.clear");
      end
    end

    // Reset in the middle of a byte
    while (mq.size() < 2) send_byte(8'($urandom), 1'b1, 1'b0);
    RXD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      RXD = i[0];
      tick(CPB);
    end
    RESET = 1'b1;
    #1;
    mq.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    check_model("reset_mid");
    RXD = 1'b1;
    tick(2);
    RESET = 1'b0;
    tick(12 * CPB);
    check_model("reset_mid.after");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
